// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU control unit.
// HALT exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        ALU_WAIT,
        MEM,
        WB
`ifdef CTRL_ILLEGAL_TRAP_EN
        , HALT
`endif
    } state_e;

    localparam int unsigned OP_LO_W = 4;
    localparam int unsigned ALU_W   = 3;

    localparam logic [OP_LO_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_LO_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_LO_W-1:0] OP_MUL  = 4'd2;
    localparam logic [OP_LO_W-1:0] OP_DIV  = 4'd3;
    localparam logic [OP_LO_W-1:0] OP_ORI  = 4'd4;
    localparam logic [OP_LO_W-1:0] OP_NOR  = 4'd5;
    localparam logic [OP_LO_W-1:0] OP_NAND = 4'd6;
    localparam logic [OP_LO_W-1:0] OP_SW   = 4'd7;
    localparam logic [OP_LO_W-1:0] OP_LW   = 4'd8;
    localparam logic [OP_LO_W-1:0] OP_BLT  = 4'd9;

    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_MUL  = 3'b010;
    localparam logic [ALU_W-1:0] ALU_DIV  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_ORI  = 3'b100;
    localparam logic [ALU_W-1:0] ALU_NOR  = 3'b101;
    localparam logic [ALU_W-1:0] ALU_NAND = 3'b110;
    localparam logic [ALU_W-1:0] MEM_ALU_CTR = 3'b000;

endpackage

// File: rtl/ctrl_op_class.sv
// Combinational classification of the latched opcode into instruction classes
// and the matching ALU operation code.
module ctrl_op_class
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W = 4
) (
    input  logic [OPC_W-1:0] op_q_i,
    output logic             is_r_o,
    output logic             is_muldiv_o,
    output logic             is_imm_o,
    output logic             is_lw_o,
    output logic             is_sw_o,
    output logic             is_blt_o,
    output logic             is_illegal_o,
    output logic [ALU_W-1:0] alu_ctr_o
);

    logic [OP_LO_W-1:0] op_lo;
    logic               hi_zero;

    // Any set bit above [3:0] makes the opcode illegal.
    assign op_lo   = op_q_i[OP_LO_W-1:0];
    assign hi_zero = ((op_q_i >> OP_LO_W) == OPC_W'(0));

    always_comb begin
        is_r_o       = 1'b0;
        is_muldiv_o  = 1'b0;
        is_imm_o     = 1'b0;
        is_lw_o      = 1'b0;
        is_sw_o      = 1'b0;
        is_blt_o     = 1'b0;
        is_illegal_o = 1'b0;
        alu_ctr_o    = MEM_ALU_CTR;
        if (!hi_zero) begin
            is_illegal_o = 1'b1;
        end else begin
            case (op_lo)
                OP_ADD:  begin is_r_o = 1'b1; alu_ctr_o = ALU_ADD; end
                OP_SUB:  begin is_r_o = 1'b1; alu_ctr_o = ALU_SUB; end
                OP_MUL:  begin is_r_o = 1'b1; is_muldiv_o = 1'b1; alu_ctr_o = ALU_MUL; end
                OP_DIV:  begin is_r_o = 1'b1; is_muldiv_o = 1'b1; alu_ctr_o = ALU_DIV; end
                OP_ORI:  begin is_imm_o = 1'b1; alu_ctr_o = ALU_ORI; end
                OP_NOR:  begin is_r_o = 1'b1; alu_ctr_o = ALU_NOR; end
                OP_NAND: begin is_r_o = 1'b1; alu_ctr_o = ALU_NAND; end
                OP_SW:   is_sw_o  = 1'b1;
                OP_LW:   is_lw_o  = 1'b1;
                OP_BLT:  is_blt_o = 1'b1;
                default: is_illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: fetch/decode/exec/alu-wait/mem/write-back sequencing.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into a sticky HALT state.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W     = 4,
    parameter bit          MULDIV_MC = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    input  logic             alu_done,
    input  logic             lt_flag,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_load,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             ext_op,
    output logic             alu_start,
    output logic [ALU_W-1:0] alu_ctr,
    output logic             illegal_op
);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   op_q, op_d;
    logic               is_r, is_muldiv, is_imm, is_lw, is_sw, is_blt, is_illegal;
    logic [ALU_W-1:0]   cls_alu_ctr;
    logic               dp_en;

    ctrl_op_class #(.OPC_W(OPC_W)) u_op_class (
        .op_q_i       (op_q),
        .is_r_o       (is_r),
        .is_muldiv_o  (is_muldiv),
        .is_imm_o     (is_imm),
        .is_lw_o      (is_lw),
        .is_sw_o      (is_sw),
        .is_blt_o     (is_blt),
        .is_illegal_o (is_illegal),
        .alu_ctr_o    (cls_alu_ctr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next state and Mealy outputs; everything is forced low while rst is high.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dp_en      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        alu_start  = 1'b0;
        illegal_op = 1'b0;

        unique case (state_q)
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                op_d    = opcode;
                state_d = EXEC;
            end
            EXEC: begin
                dp_en = 1'b1;
                if (is_blt) begin
                    pc_write = lt_flag;
                    pc_src   = 1'b1;
                    state_d  = FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = MEM;
                end else if (is_muldiv && MULDIV_MC) begin
                    alu_start = 1'b1;
                    state_d   = ALU_WAIT;
                end else if (is_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    illegal_op = 1'b1;
                    state_d    = HALT;
`else
                    state_d    = FETCH;
`endif
                end else begin
                    state_d = WB;
                end
            end
            ALU_WAIT: begin
                dp_en = 1'b1;
                if (alu_done) state_d = WB;
            end
            MEM: begin
                dp_en     = 1'b1;
                mem_read  = is_lw;
                mem_write = !is_lw;
                if (mem_ready) state_d = is_lw ? WB : FETCH;
            end
            WB: begin
                dp_en     = 1'b1;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            HALT: state_d = HALT;
`endif
            default: state_d = FETCH;
        endcase

        // Datapath controls follow the latched instruction from EXEC to WB.
        reg_dst    = dp_en & is_r;
        alu_src    = dp_en & (is_imm | is_lw | is_sw);
        mem_to_reg = dp_en & is_lw;
        ext_op     = dp_en & (is_lw | is_sw);
        alu_ctr    = dp_en ? cls_alu_ctr : MEM_ALU_CTR;

        if (rst) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_load    = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            reg_dst    = 1'b0;
            alu_src    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            ext_op     = 1'b0;
            alu_start  = 1'b0;
            alu_ctr    = '0;
            illegal_op = 1'b0;
        end
    end

endmodule
